// File: rtl/counter_dram_burst.sv
// counter_dram_burst: DRAM read burst beat counter with latency wait, last-beat flag, done pulse and auto-reload
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous reset, active-low; clears all state
//   i_start        begin a burst (IDLE only); latches i_len / i_lat
//   i_stop         synchronous abort, overrides start and last beat
//   i_beat         data beat valid, counted only in COUNT
//   i_len          beats per burst, 0 means 2^CNT_W
//   i_lat          wait cycles between start and first countable beat
//   i_auto_reload  at burst end re-arm with latched len/lat instead of going IDLE
//   o_busy         state is not IDLE
//   o_count        beats received in the current burst
//   o_last         current beat is the final beat of the burst
//   o_done         one-cycle pulse the cycle after the final beat
//   o_err          sticky beat timeout flag
//
// Optional feature: define COUNTER_DRAM_TIMEOUT_EN to abort a burst after TIMEOUT
// consecutive beatless COUNT cycles and raise o_err; otherwise o_err is tied 0.
module counter_dram_burst #(
    parameter int CNT_W   = 8,
    parameter int LAT_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_beat,
    input  logic [CNT_W-1:0] i_len,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_auto_reload,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last,
    output logic             o_done,
    output logic             o_err
);
    typedef enum logic [1:0] {IDLE, WAIT, COUNT} state_t;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_len;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] r_dly;
    logic             r_done;
    logic [CNT_W-1:0] w_len_m1;
    logic             w_last;
    logic             w_tmo;
    // len 0 wraps to all-ones here, giving a 2^CNT_W beat burst
    assign w_len_m1 = r_len - CNT_W'(1);
    assign w_last   = (r_state == COUNT) && i_beat && (r_count == w_len_m1);
`ifdef COUNTER_DRAM_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] r_idle;
    logic          r_err;
    assign w_tmo = (r_state == COUNT) && !i_beat && (r_idle == IW'(TIMEOUT - 1));
    // r_idle is zero outside COUNT, so COUNT entry always starts from a cleared count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle <= '0;
            r_err  <= 1'b0;
        end else begin
            r_idle <= (r_state == COUNT && !i_beat) ? r_idle + IW'(1) : '0;
            if (!i_stop && r_state == IDLE && i_start)
                r_err <= 1'b0;
            else if (!i_stop && w_tmo)
                r_err <= 1'b1;
        end
    end
    assign o_err = r_err;
`else
    assign w_tmo = 1'b0;
    assign o_err = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_len   <= '0;
            r_lat   <= '0;
            r_dly   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_stop || w_tmo) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    IDLE: if (i_start) begin
                        r_len   <= i_len;
                        r_lat   <= i_lat;
                        r_dly   <= i_lat;
                        r_count <= '0;
                        r_state <= (i_lat == '0) ? COUNT : WAIT;
                    end
                    WAIT: begin
                        r_dly <= r_dly - LAT_W'(1);
                        if (r_dly == LAT_W'(1))
                            r_state <= COUNT;
                    end
                    COUNT: if (w_last) begin
                        r_count <= '0;
                        r_done  <= 1'b1;
                        r_dly   <= r_lat;
                        r_state <= !i_auto_reload ? IDLE : (r_lat == '0) ? COUNT : WAIT;
                    end else if (i_beat) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign o_busy  = (r_state != IDLE);
    assign o_count = r_count;
    assign o_last  = w_last;
    assign o_done  = r_done;
endmodule

// File: tb/tb_counter_dram_burst.sv
// tb_counter_dram_burst: scoreboard bench for counter_dram_burst (CNT_W=4, TIMEOUT=5)
module tb_counter_dram_burst;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       beat = 1'b0;
    logic       ar = 1'b0;
    logic [3:0] len = '0;
    logic [3:0] lat = '0;
    logic       busy, last, done, err;
    logic [3:0] count;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int s;
    int q_last_cyc[$], q_last_cnt[$], q_done_cyc[$], q_done_busy[$];

    counter_dram_burst #(.CNT_W(4), .LAT_W(4), .TIMEOUT(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_beat(beat),
        .i_len(len), .i_lat(lat), .i_auto_reload(ar),
        .o_busy(busy), .o_count(count), .o_last(last), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic exp_last(input int c, input int n);
        q_last_cyc.push_back(c);
        q_last_cnt.push_back(n);
    endtask

    task automatic exp_done(input int c, input int b);
        q_done_cyc.push_back(c);
        q_done_busy.push_back(b);
    endtask

    always @(negedge clk) begin
        if (rst_n && last) begin
            if (q_last_cyc.size() == 0)
                chk("unexpected_last", 1, 0);
            else begin
                chk("last_cycle", cyc, q_last_cyc.pop_front());
                chk("last_count", int'(count), q_last_cnt.pop_front());
            end
        end
        if (rst_n && done) begin
            if (q_done_cyc.size() == 0)
                chk("unexpected_done", 1, 0);
            else begin
                chk("done_cycle", cyc, q_done_cyc.pop_front());
                chk("done_busy", int'(busy), q_done_busy.pop_front());
            end
        end
    end

    initial begin
        start = 1'b1; beat = 1'b1; len = 4'd4;
        repeat (3) tick;
        at_neg;
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last, 0);
        chk("rst_err", err, 0);
        tick;
        rst_n = 1'b1; start = 1'b0; beat = 1'b0;
        tick;
        // basic burst: len 4, no latency
        s = cyc; start = 1'b1; len = 4'd4; lat = 4'd0; beat = 1'b1; ar = 1'b0;
        exp_last(s + 4, 3); exp_done(s + 5, 0);
        tick;
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            at_neg;
            chk("basic_count", count, i % 4);
        end
        chk("basic_busy_end", busy, 0);
        beat = 1'b0;
        tick;
        // latency 3, len 2
        tick;
        s = cyc; start = 1'b1; len = 4'd2; lat = 4'd3; beat = 1'b1;
        exp_last(s + 5, 1); exp_done(s + 6, 0);
        tick;
        start = 1'b0;
        tick; tick;
        at_neg;
        chk("wait_count", count, 0);
        chk("wait_busy", busy, 1);
        repeat (4) tick;
        beat = 1'b0;
        // auto-reload, beat toggling; a start mid-burst with new len/lat is ignored
        tick;
        s = cyc; start = 1'b1; len = 4'd3; lat = 4'd1; ar = 1'b1; beat = 1'b1;
        exp_last(s + 6, 2);  exp_done(s + 7, 1);
        exp_last(s + 12, 2); exp_done(s + 13, 1);
        exp_last(s + 18, 2); exp_done(s + 19, 0);
        for (int c = 1; c <= 20; c++) begin
            tick;
            start = (c == 9);
            beat = (c % 2 == 0);
            if (c == 9) begin len = 4'd7; lat = 4'd5; end
            if (c == 15) ar = 1'b0;
        end
        at_neg;
        chk("reload_end_busy", busy, 0);
        beat = 1'b0;
        // full range: len 0 means 16 beats
        tick;
        s = cyc; start = 1'b1; len = 4'd0; lat = 4'd0; beat = 1'b1;
        exp_last(s + 16, 15); exp_done(s + 17, 0);
        tick;
        start = 1'b0;
        repeat (7) tick;
        at_neg;
        chk("full_mid_count", count, 7);
        repeat (10) tick;
        beat = 1'b0;
        // abort at count 2 with coincident start, then restart
        tick;
        s = cyc; start = 1'b1; len = 4'd8; lat = 4'd0; beat = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        at_neg;
        chk("abort_pre_count", count, 2);
        stop = 1'b1; start = 1'b1;
        tick;
        at_neg;
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        tick;
        at_neg;
        chk("abort_start_blocked", busy, 0);
        stop = 1'b0; start = 1'b1; len = 4'd2; lat = 4'd0;
        exp_last(s + 7, 1); exp_done(s + 8, 0);
        tick;
        start = 1'b0;
        repeat (3) tick;
        beat = 1'b0;
        // asynchronous reset mid-burst
        tick;
        start = 1'b1; len = 4'd8; lat = 4'd0; beat = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        chk("arst_last", last, 0);
        chk("arst_done", done, 0);
        tick; tick;
        rst_n = 1'b1;
        tick; tick;
        at_neg;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        beat = 1'b0;
`ifdef COUNTER_DRAM_TIMEOUT_EN
        tick;
        s = cyc; start = 1'b1; len = 4'd4; lat = 4'd0; beat = 1'b0;
        tick;
        start = 1'b0; beat = 1'b1;
        tick;
        beat = 1'b0;
        repeat (4) tick;
        at_neg;
        chk("tmo_err_pre", err, 0);
        chk("tmo_busy_pre", busy, 1);
        tick;
        at_neg;
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_count", count, 0);
        tick;
        start = 1'b1; len = 4'd4; lat = 4'd2;
        tick;
        start = 1'b0;
        at_neg;
        chk("tmo_err_clear", err, 0);
        rst_n = 1'b0;
        #1;
        chk("tmo_arst_busy", busy, 0);
        chk("tmo_arst_err", err, 0);
        tick; tick;
        rst_n = 1'b1;
`else
        chk("err_tied_low", err, 0);
`endif
        repeat (3) tick;
        chk("pending_last", q_last_cyc.size(), 0);
        chk("pending_done", q_done_cyc.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/counter_dram_burst.md
Name: counter_dram_burst

Overview:
- Parametrised DRAM burst beat counter. Successor to the fixed 4-bit load/stop counter used on the DRAM read-data path.
- Adds a programmable read-latency wait phase, a burst length latched at start, and a last-beat flag.
- Emits a one-cycle done pulse and supports auto-reload for back-to-back bursts.
- Sits between the DRAM wrapper and the AXI read-data channel logic; terminates bursts and drives RLAST.

Parameters:
- CNT_W, 8, width of the beat counter and of len.
- LAT_W, 4, width of the latency field lat.
- TIMEOUT, 255, max idle cycles between beats in COUNT; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; all state cleared while rst=0.
- start  in  1  begin a burst; sampled only in IDLE.
- stop  in  1  synchronous abort; highest priority after reset.
- beat  in  1  data beat valid from DRAM; counted only in COUNT.
- len  in  CNT_W  beats per burst; 0 means 2^CNT_W.
- lat  in  LAT_W  wait cycles between start and first countable beat.
- auto_reload  in  1  at burst end, re-arm with the latched len/lat instead of returning to IDLE.
- busy  out  1  state != IDLE.
- count  out  CNT_W  beats received in the current burst.
- last  out  1  combinational: state==COUNT && beat && count==len_q-1.
- done  out  1  one-cycle pulse, registered, the cycle after the last beat.
- err  out  1  sticky timeout flag (optional feature).

Behaviour:
- Reset (rst=0, async): state=IDLE; count, len_q, lat_q, dly, done, err all 0.
- IDLE:
  - start=1: latch len_q=len, lat_q=lat.
  - lat==0 → COUNT next cycle. Else → WAIT with dly=lat.
- WAIT:
  - dly decrements each cycle; at dly==1 → COUNT.
  - If start is at edge T, COUNT is active from cycle T+1+lat.
  - Beats in WAIT are ignored.
- COUNT:
  - beat=1: count increments modulo 2^CNT_W.
  - Beat with count==len_q-1 (the last beat): count→0, done=1 in the next cycle.
  - After the last beat: auto_reload=1 → WAIT (dly=lat_q) or COUNT if lat_q==0; auto_reload=0 → IDLE.
  - auto_reload is sampled on the last-beat cycle.
- len=0: len_q-1 wraps to all-ones, so the burst is 2^CNT_W beats.
- stop=1 in any state: next cycle state=IDLE, count=0, no done pulse. stop overrides a coincident start or last beat. err is unaffected.
- start while busy is ignored. len/lat changes after start have no effect on the burst in flight.
- busy drops in the cycle done is asserted, unless reloading.
- count is held when beat=0. Beats in IDLE are ignored.
- Reset mid-burst aborts immediately. No done pulse after reset release.

Optional Feature:
- Macro: COUNTER_DRAM_TIMEOUT_EN.
- Defined:
  - An idle counter (width clog2(TIMEOUT+1)) clears on each beat and on COUNT entry, and increments on non-beat COUNT cycles.
  - On reaching TIMEOUT: err=1 (sticky until rst or next start), state→IDLE, count=0, no done.
- Undefined: COUNT waits indefinitely for beats; err is tied 0; TIMEOUT is unused.

Test Plan:
- Basic burst: rst release; start, len=4, lat=0, beat held 1 → count 1,2,3,0; last high on the 4th beat cycle; done pulse 1 cycle later; busy low with done.
- Latency: len=2, lat=3, start at cycle 10, beat held 1 → beats in cycles 11-13 ignored; counted at 14 and 15; last at 15; done at 16.
- Auto-reload with gaps: len=3, lat=1, auto_reload=1, beat toggling 1/0 → bursts repeat with a 1-cycle WAIT between them; done pulses every 3 counted beats; busy stays high.
- Full-range: CNT_W=4, len=0 → 16 beats counted; last on count==15; done once.
- Abort: stop=1 at count=2 of len=8, coincident with start → IDLE next cycle, count=0, no done; restart works.
- Timeout (COUNTER_DRAM_TIMEOUT_EN, TIMEOUT=5): start, len=4, one beat then beat=0 → err=1 after 5 idle cycles, state IDLE, no done; async rst low mid-burst → all outputs 0 immediately.
